// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE payload, aligns and extends SRAM load data, and holds the
// load word across WB back-pressure so the write-back value stays stable during a stall.
module mem_stage #(
    parameter int unsigned EXW = 82
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           es2ms_valid,
    output logic           ms_allowin,
    input  logic [31:0]    es_pc,
    input  logic [4:0]     es_ld_op,
    input  logic           es_res_from_mem,
    input  logic           es_rf_we,
    input  logic [4:0]     es_rf_waddr,
    input  logic [31:0]    es_rf_result,
    input  logic           es_csr_re,
    input  logic [EXW-1:0] es_except,
    input  logic           es_except_ale,
    input  logic [31:0]    data_sram_rdata,
    input  logic           ws_allowin,
    input  logic           wb_ex,
    output logic           ms2ws_valid,
    output logic [31:0]    ms_pc,
    output logic           ms_rf_we,
    output logic [4:0]     ms_rf_waddr,
    output logic [31:0]    ms_rf_wdata,
    output logic [EXW:0]   ms_except,
    output logic           ms_ex,
    output logic [38:0]    ms_rf_zip
);

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b00010;

    logic           ms_valid_q, ms_valid_d;
    logic [31:0]    pc_q, pc_d;
    logic [4:0]     ld_op_q, ld_op_d;
    logic           res_from_mem_q, res_from_mem_d;
    logic           rf_we_q, rf_we_d;
    logic [4:0]     rf_waddr_q, rf_waddr_d;
    logic [31:0]    rf_result_q, rf_result_d;
    logic           csr_re_q, csr_re_d;
    logic [EXW-1:0] except_q, except_d;
    logic           ale_q, ale_d;
    logic           first_q, first_d;
    logic [31:0]    buf_q, buf_d;
    logic           buf_vld_q, buf_vld_d;

    logic           capture;
    logic [31:0]    load_word;
    logic [1:0]     off;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_data;

    assign ms_allowin = ~ms_valid_q | ws_allowin;
    assign capture    = es2ms_valid & ms_allowin & ~wb_ex;

    // Next-state: valid/flush, payload capture, and load-word hold on a first-cycle stall
    always_comb begin
        ms_valid_d     = ms_valid_q;
        pc_d           = pc_q;
        ld_op_d        = ld_op_q;
        res_from_mem_d = res_from_mem_q;
        rf_we_d        = rf_we_q;
        rf_waddr_d     = rf_waddr_q;
        rf_result_d    = rf_result_q;
        csr_re_d       = csr_re_q;
        except_d       = except_q;
        ale_d          = ale_q;
        first_d        = 1'b0;
        buf_d          = buf_q;
        buf_vld_d      = buf_vld_q;

        if (wb_ex) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es2ms_valid;
        end

        if (capture) begin
            pc_d           = es_pc;
            ld_op_d        = es_ld_op;
            res_from_mem_d = es_res_from_mem;
            rf_we_d        = es_rf_we;
            rf_waddr_d     = es_rf_waddr;
            rf_result_d    = es_rf_result;
            csr_re_d       = es_csr_re;
            except_d       = es_except;
            ale_d          = es_except_ale;
            first_d        = 1'b1;
            buf_vld_d      = 1'b0;
        end else if (wb_ex) begin
            buf_vld_d = 1'b0;
        end else if (first_q && ms_valid_q && res_from_mem_q && !ws_allowin) begin
            // SRAM data is only valid in the first cycle; keep a copy for the rest of the stall
            buf_d     = data_sram_rdata;
            buf_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q     <= 1'b0;
            pc_q           <= 32'h0;
            ld_op_q        <= 5'h0;
            res_from_mem_q <= 1'b0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= 5'h0;
            rf_result_q    <= 32'h0;
            csr_re_q       <= 1'b0;
            except_q       <= '0;
            ale_q          <= 1'b0;
            first_q        <= 1'b0;
            buf_q          <= 32'h0;
            buf_vld_q      <= 1'b0;
        end else begin
            ms_valid_q     <= ms_valid_d;
            pc_q           <= pc_d;
            ld_op_q        <= ld_op_d;
            res_from_mem_q <= res_from_mem_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_result_q    <= rf_result_d;
            csr_re_q       <= csr_re_d;
            except_q       <= except_d;
            ale_q          <= ale_d;
            first_q        <= first_d;
            buf_q          <= buf_d;
            buf_vld_q      <= buf_vld_d;
        end
    end

    // Load alignment and extension
    always_comb begin
        load_word = buf_vld_q ? buf_q : data_sram_rdata;
        off       = rf_result_q[1:0];
        ld_byte   = load_word[{off, 3'b000} +: 8];
        ld_half   = off[1] ? load_word[31:16] : load_word[15:0];
        case (ld_op_q)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {24'h0, ld_byte};
            LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = load_word;
        endcase
    end

    assign ms_rf_wdata = res_from_mem_q ? ld_data : rf_result_q;
    assign ms2ws_valid = ms_valid_q;
    assign ms_pc       = pc_q;
    assign ms_rf_waddr = rf_waddr_q;
    assign ms_except   = {except_q, ale_q};
    assign ms_ex       = ms_valid_q & ((|except_q[5:0]) | ale_q);
    assign ms_rf_we    = ms_valid_q & rf_we_q & ~ms_ex;
    assign ms_rf_zip   = {csr_re_q & ms_valid_q, ms_rf_we, ms_rf_waddr, ms_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written stall/flush/reset sequences, then
// randomized traffic checked against a transaction-level reference model.
module tb_mem_stage;

    localparam int unsigned EXW = 82;
    localparam logic [4:0] OP_B = 5'b10000, OP_BU = 5'b01000, OP_H = 5'b00100,
                           OP_HU = 5'b00010, OP_W = 5'b00001;

    logic           clk, reset, es2ms_valid, ms_allowin;
    logic [31:0]    es_pc;
    logic [4:0]     es_ld_op;
    logic           es_res_from_mem, es_rf_we;
    logic [4:0]     es_rf_waddr;
    logic [31:0]    es_rf_result;
    logic           es_csr_re;
    logic [EXW-1:0] es_except;
    logic           es_except_ale;
    logic [31:0]    data_sram_rdata;
    logic           ws_allowin, wb_ex, ms2ws_valid;
    logic [31:0]    ms_pc;
    logic           ms_rf_we;
    logic [4:0]     ms_rf_waddr;
    logic [31:0]    ms_rf_wdata;
    logic [EXW:0]   ms_except;
    logic           ms_ex;
    logic [38:0]    ms_rf_zip;

    mem_stage #(.EXW(EXW)) dut (
        .clk(clk), .reset(reset), .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_ld_op(es_ld_op), .es_res_from_mem(es_res_from_mem),
        .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_rf_result(es_rf_result),
        .es_csr_re(es_csr_re), .es_except(es_except), .es_except_ale(es_except_ale),
        .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .wb_ex(wb_ex),
        .ms2ws_valid(ms2ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
        .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata), .ms_except(ms_except),
        .ms_ex(ms_ex), .ms_rf_zip(ms_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one in-flight instruction plus the load word seen in its first cycle
    logic           m_valid, m_first, m_rfm, m_we, m_csr, m_ale;
    logic [31:0]    m_pc, m_res, m_word;
    logic [4:0]     m_ldop, m_waddr;
    logic [EXW-1:0] m_exc;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        logic [31:0] rdata;
        logic        ale;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic        exp_ex;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (addr % 4))) & 32'hFF;
        h = ((addr % 4) >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            OP_B:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            OP_BU:   return b;
            OP_H:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            OP_HU:   return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_first = 0; m_rfm = 0; m_we = 0; m_csr = 0; m_ale = 0;
        m_pc = 0; m_res = 0; m_word = 0; m_ldop = 0; m_waddr = 0; m_exc = '0;
    endtask

    task automatic model_update();
        logic allow, cap;
        if (reset) begin
            model_reset();
            return;
        end
        allow = !m_valid || ws_allowin;
        cap   = es2ms_valid && allow && !wb_ex;
        if (m_first) m_word = data_sram_rdata;
        if (cap) begin
            m_pc = es_pc; m_ldop = es_ld_op; m_rfm = es_res_from_mem; m_we = es_rf_we;
            m_waddr = es_rf_waddr; m_res = es_rf_result; m_csr = es_csr_re;
            m_exc = es_except; m_ale = es_except_ale;
        end
        m_first = cap;
        if (wb_ex) m_valid = 0;
        else if (allow) m_valid = es2ms_valid;
    endtask

    task automatic model_check();
        logic        e_ex, e_we;
        logic [31:0] e_wd;
        e_ex = m_valid && ((m_exc[5:0] != 0) || m_ale);
        e_we = m_valid && m_we && !e_ex;
        e_wd = m_rfm ? ref_load(m_ldop, m_res, m_first ? data_sram_rdata : m_word) : m_res;
        chk("allowin", 128'(ms_allowin), 128'(!m_valid || ws_allowin));
        chk("ms2ws_valid", 128'(ms2ws_valid), 128'(m_valid));
        chk("ms_ex", 128'(ms_ex), 128'(e_ex));
        chk("ms_rf_we", 128'(ms_rf_we), 128'(e_we));
        chk("ms_pc", 128'(ms_pc), 128'(m_pc));
        chk("ms_except", 128'(ms_except), 128'({m_exc, m_ale}));
        if (m_valid) begin
            chk("ms_rf_wdata", 128'(ms_rf_wdata), 128'(e_wd));
            chk("ms_rf_zip", 128'(ms_rf_zip), 128'({m_csr, e_we, m_waddr, e_wd}));
        end else begin
            chk("zip_hi_idle", 128'(ms_rf_zip[38:37]), 128'(0));
        end
    endtask

    // Advance one clock: model follows the edge, new inputs go on at the falling edge
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        es2ms_valid = 0; es_pc = 0; es_ld_op = 0; es_res_from_mem = 0; es_rf_we = 0;
        es_rf_waddr = 0; es_rf_result = 0; es_csr_re = 0; es_except = '0; es_except_ale = 0;
        data_sram_rdata = 0; ws_allowin = 1; wb_ex = 0;
    endtask

    task automatic put_instr(input logic [4:0] op, input logic [31:0] res, input logic ale);
        es2ms_valid = 1; es_pc = 32'h1C00_0000 + res; es_ld_op = op;
        es_res_from_mem = |op; es_rf_we = 1; es_rf_waddr = 5'd7; es_rf_result = res;
        es_csr_re = 0; es_except = '0; es_except_ale = ale;
    endtask

    initial begin
        tbl[0] = '{OP_B,  32'h1003, 32'h8012_3456, 1'b0, 32'hFFFF_FF80, 1'b1, 1'b0};
        tbl[1] = '{OP_HU, 32'h2002, 32'hBEEF_1234, 1'b0, 32'h0000_BEEF, 1'b1, 1'b0};
        tbl[2] = '{OP_H,  32'h2002, 32'hBEEF_1234, 1'b0, 32'hFFFF_BEEF, 1'b1, 1'b0};
        tbl[3] = '{OP_BU, 32'h0001, 32'h1122_8033, 1'b0, 32'h0000_0080, 1'b1, 1'b0};
        tbl[4] = '{OP_B,  32'h0000, 32'h1122_337F, 1'b0, 32'h0000_007F, 1'b1, 1'b0};
        tbl[5] = '{OP_H,  32'h0000, 32'h0000_8001, 1'b0, 32'hFFFF_8001, 1'b1, 1'b0};
        tbl[6] = '{OP_W,  32'h0000, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0};
        tbl[7] = '{5'h0,  32'h1234_5678, 32'h9999_9999, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
        tbl[8] = '{OP_W,  32'h1001, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA, 1'b0, 1'b1};

        set_idle();
        reset = 0;
        model_reset();
        #1 reset = 1;
        #1;
        chk("rst_allowin", 128'(ms_allowin), 128'(1));
        chk("rst_outputs", 128'({ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
                                 ms_ex}), 128'(0));
        chk("rst_except_zip", 128'({ms_except, ms_rf_zip}), 128'(0));
        @(negedge clk);
        reset = 0;

        // Directed load/alignment table
        for (int i = 0; i < 9; i++) begin
            set_idle();
            put_instr(tbl[i].op, tbl[i].res, tbl[i].ale);
            tick();
            es2ms_valid = 0;
            data_sram_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("tbl%0d_wdata", i), 128'(ms_rf_wdata), 128'(tbl[i].exp_wdata));
            chk($sformatf("tbl%0d_we", i), 128'(ms_rf_we), 128'(tbl[i].exp_we));
            chk($sformatf("tbl%0d_ex", i), 128'(ms_ex), 128'(tbl[i].exp_ex));
            chk($sformatf("tbl%0d_ale", i), 128'(ms_except[0]), 128'(tbl[i].ale));
            chk($sformatf("tbl%0d_zipwe", i), 128'(ms_rf_zip[37]), 128'(tbl[i].exp_we));
            tick();
        end

        // Load held across a three-cycle WB stall while SRAM data changes underneath
        set_idle();
        put_instr(OP_W, 32'h3000, 1'b0);
        tick();
        put_instr(OP_B, 32'h4000, 1'b0);
        ws_allowin = 0;
        data_sram_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_wdata", c), 128'(ms_rf_wdata), 128'(32'hCAFE_F00D));
            chk($sformatf("stall%0d_allowin", c), 128'(ms_allowin), 128'(0));
            chk($sformatf("stall%0d_valid", c), 128'(ms2ws_valid), 128'(1));
            tick();
            data_sram_rdata = 32'hDEAD_BEEF;
        end
        es2ms_valid = 0;
        ws_allowin = 1;
        tick();
        #1 chk("stall_drain_valid", 128'(ms2ws_valid), 128'(0));

        // Flush during a stall with the buffer loaded, then flush colliding with an idle capture
        put_instr(OP_W, 32'h5000, 1'b0);
        tick();
        es2ms_valid = 0; ws_allowin = 0; data_sram_rdata = 32'h1111_2222;
        tick();
        put_instr(OP_W, 32'h6000, 1'b0);
        wb_ex = 1;
        tick();
        #1;
        chk("flush1_valid", 128'(ms2ws_valid), 128'(0));
        chk("flush1_allowin", 128'(ms_allowin), 128'(1));
        put_instr(OP_W, 32'h7000, 1'b0);
        wb_ex = 1; ws_allowin = 1;
        tick();
        #1;
        chk("flush2_valid", 128'(ms2ws_valid), 128'(0));
        chk("flush2_allowin", 128'(ms_allowin), 128'(1));
        chk("flush2_we", 128'(ms_rf_we), 128'(0));
        wb_ex = 0;
        put_instr(OP_W, 32'h8000, 1'b0);
        tick();
        es2ms_valid = 0; data_sram_rdata = 32'h1357_9BDF;
        #1 chk("post_flush_live_rdata", 128'(ms_rf_wdata), 128'(32'h1357_9BDF));
        tick();

        // Asynchronous reset in the middle of a buffered stall
        put_instr(OP_W, 32'h9000, 1'b0);
        tick();
        es2ms_valid = 0; ws_allowin = 0; data_sram_rdata = 32'hA5A5_A5A5;
        tick();
        #1 chk("pre_rst_wdata", 128'(ms_rf_wdata), 128'(32'hA5A5_A5A5));
        reset = 1;
        #1;
        chk("mid_rst_allowin", 128'(ms_allowin), 128'(1));
        chk("mid_rst_outputs", 128'({ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
                                     ms_ex}), 128'(0));
        chk("mid_rst_except_zip", 128'({ms_except, ms_rf_zip}), 128'(0));
        tick();
        set_idle();
        reset = 0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] ops [6];
            ops[0] = 5'h0; ops[1] = OP_B; ops[2] = OP_BU;
            ops[3] = OP_H; ops[4] = OP_HU; ops[5] = OP_W;
            es2ms_valid     = ($urandom_range(0, 9) < 7);
            es_pc           = $urandom;
            es_ld_op        = ops[$urandom_range(0, 5)];
            es_res_from_mem = |es_ld_op;
            es_rf_we        = ($urandom_range(0, 7) != 0);
            es_rf_waddr     = 5'($urandom);
            es_rf_result    = $urandom;
            es_csr_re       = ($urandom_range(0, 5) == 0);
            es_except       = {18'($urandom), $urandom, $urandom};
            if ($urandom_range(0, 4) != 0) es_except[5:0] = 6'h0;
            es_except_ale   = ($urandom_range(0, 9) == 0);
            data_sram_rdata = $urandom;
            ws_allowin      = ($urandom_range(0, 9) < 6);
            wb_ex           = ($urandom_range(0, 19) == 0);
            #1 model_check();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
